// File: rtl/vol_pkg.sv
// -----------------------------------------------------------------------------
// vol_pkg
//   Shared types and elaboration-time helpers for the volatility sample-buffer
//   write scheduler.
//   - id_width / addr_width / cnt_width : derived field widths
//   - part_base                         : first buffer address of a stock
//                                         partition. It is only ever evaluated
//                                         on constants to build a lookup table.
//   - stock_id_t                        : stock index at default sizing
//   - sched_state_t                     : two-state stall FSM encoding
// -----------------------------------------------------------------------------
package vol_pkg;

  localparam int NUM_STOCKS_DEF  = 4;
  localparam int BUFFER_SIZE_DEF = 20;
  localparam int DATA_WIDTH_DEF  = 32;

  // A single stock still needs a 1-bit id field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_width(input int n, input int b);
    return ((n * b) > 1) ? $clog2(n * b) : 1;
  endfunction

  function automatic int cnt_width(input int b);
    return $clog2(b + 1);
  endfunction

  function automatic int part_base(input int s, input int b);
    return s * b;
  endfunction

  typedef logic [id_width(NUM_STOCKS_DEF)-1:0] stock_id_t;

  typedef enum logic [0:0] {
    ST_ACCEPT   = 1'b0,
    ST_WAIT_ACK = 1'b1
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter. The search starts at requester rr_i and
//   wraps. The first requester found wins.
//   Ports:
//     req_i      [N]    request vector
//     rr_i       [ID_W] highest-priority requester this cycle
//     gnt_o      [N]    one-hot grant, all zero if nothing is requested
//     gnt_id_o   [ID_W] encoded id of the winner (0 when no grant)
//     gnt_any_o         some requester was granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] rr_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            gnt_any_o
);

  // Priority search that starts at rr_i. The wrap uses a subtract, not a modulo.
  always_comb begin
    int  idx;
    logic hit;
    gnt_o     = '0;
    gnt_id_o  = '0;
    gnt_any_o = 1'b0;
    idx       = 0;
    hit       = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx       = ((int'(rr_i) + i) >= N) ? (int'(rr_i) + i - N) : (int'(rr_i) + i);
      hit       = req_i[idx] & ~gnt_any_o;
      gnt_o[idx] = gnt_o[idx] | hit;
      gnt_id_o  = hit ? ID_W'(idx) : gnt_id_o;
      gnt_any_o = gnt_any_o | hit;
    end
  end

endmodule

// File: rtl/volatility_wr_sched.sv
// -----------------------------------------------------------------------------
// volatility_wr_sched
//   Shares the single write port of the per-stock volatility sample buffer
//   between NUM_STOCKS price feeds. It arbitrates round-robin and keeps a
//   circular write pointer and a fill count for each stock. It issues one
//   registered write per accepted sample. Once a stock's window is full, every
//   further sample raises a window-ready event. That event is held until the
//   calculator accepts it.
//   Ports:
//     i_clk, i_reset_n  clock, synchronous active-low reset
//     i_req_valid/data  per-stock sample handshake (stock s at s*DATA_WIDTH)
//     o_req_ready       one-hot grant (combinational, may depend on valid)
//     i_flush           per-stock window clear
//     o_wr_en/addr/data/stock_id   registered buffer write
//     o_win_valid/stock_id/oldest  window-ready event, i_win_ready accepts it
// -----------------------------------------------------------------------------
module volatility_wr_sched
  import vol_pkg::*;
#(
  parameter  int NUM_STOCKS  = 4,
  parameter  int BUFFER_SIZE = 20,
  parameter  int DATA_WIDTH  = 32,
  localparam int ID_W        = id_width(NUM_STOCKS),
  localparam int ADDR_W      = addr_width(NUM_STOCKS, BUFFER_SIZE),
  localparam int CNT_W       = cnt_width(BUFFER_SIZE)
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic [NUM_STOCKS-1:0]            i_req_valid,
  input  logic [NUM_STOCKS*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_STOCKS-1:0]            o_req_ready,
  input  logic [NUM_STOCKS-1:0]            i_flush,
  output logic                             o_wr_en,
  output logic [ADDR_W-1:0]                o_wr_addr,
  output logic [DATA_WIDTH-1:0]            o_wr_data,
  output logic [ID_W-1:0]                  o_wr_stock_id,
  output logic                             o_win_valid,
  input  logic                             i_win_ready,
  output logic [ID_W-1:0]                  o_win_stock_id,
  output logic [ADDR_W-1:0]                o_win_oldest
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_SIZE);
  localparam logic [CNT_W-1:0] PTR_LAST = CNT_W'(BUFFER_SIZE - 1);

  // Per-stock state
  logic [CNT_W-1:0]      ptr_q [NUM_STOCKS];
  logic [CNT_W-1:0]      ptr_d [NUM_STOCKS];
  logic [CNT_W-1:0]      cnt_q [NUM_STOCKS];
  logic [CNT_W-1:0]      cnt_d [NUM_STOCKS];
  logic [ID_W-1:0]       rr_q, rr_d;
  sched_state_t          state_q, state_d;

  // Output registers
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ID_W-1:0]       wr_id_q, wr_id_d;
  logic [ID_W-1:0]       win_id_q, win_id_d;
  logic [ADDR_W-1:0]     win_old_q, win_old_d;

  // Combinational
  logic [ADDR_W-1:0]     base_tbl_s [NUM_STOCKS];
  logic [NUM_STOCKS-1:0] cand_s, arb_gnt_s;
  logic [ID_W-1:0]       arb_id_s;
  logic                  arb_any_s, stall_s, grant_s, win_event_s;
  logic [CNT_W-1:0]      sel_ptr_s, sel_cnt_s, ptr_nxt_s, cnt_nxt_s;
  logic [ADDR_W-1:0]     sel_base_s;
  logic [DATA_WIDTH-1:0] sel_data_s;

  // Partition bases are elaboration constants, so no multiplier is built.
  for (genvar s = 0; s < NUM_STOCKS; s++) begin : g_base
    assign base_tbl_s[s] = ADDR_W'(part_base(s, BUFFER_SIZE));
  end

  // A flush beats a same-cycle request from that stock.
  assign cand_s = i_req_valid & ~i_flush;

  rr_arbiter #(
    .N    (NUM_STOCKS),
    .ID_W (ID_W)
  ) u_arb (
    .req_i     (cand_s),
    .rr_i      (rr_q),
    .gnt_o     (arb_gnt_s),
    .gnt_id_o  (arb_id_s),
    .gnt_any_o (arb_any_s)
  );

  // No transfer is accepted while an unaccepted event is pending or while reset is asserted.
  assign stall_s     = (state_q == ST_WAIT_ACK) & ~i_win_ready;
  assign grant_s     = arb_any_s & ~stall_s & i_reset_n;
  assign o_req_ready = grant_s ? arb_gnt_s : {NUM_STOCKS{1'b0}};

  // Select the granted stock's pointer, count, base and sample.
  always_comb begin
    sel_ptr_s  = '0;
    sel_cnt_s  = '0;
    sel_base_s = '0;
    sel_data_s = '0;
    for (int s = 0; s < NUM_STOCKS; s++) begin
      if (arb_id_s == ID_W'(s)) begin
        sel_ptr_s  = ptr_q[s];
        sel_cnt_s  = cnt_q[s];
        sel_base_s = base_tbl_s[s];
        sel_data_s = i_req_data[s*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        sel_ptr_s  = sel_ptr_s;
      end
    end
  end

  assign ptr_nxt_s   = (sel_ptr_s == PTR_LAST) ? {CNT_W{1'b0}} : (sel_ptr_s + CNT_W'(1));
  assign cnt_nxt_s   = (sel_cnt_s == CNT_FULL) ? CNT_FULL : (sel_cnt_s + CNT_W'(1));
  assign win_event_s = grant_s & (cnt_nxt_s == CNT_FULL);

  // Next state of the per-stock pointers and counts. Flush and grant never hit the same stock.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    for (int s = 0; s < NUM_STOCKS; s++) begin
      if (i_flush[s]) begin
        ptr_d[s] = '0;
        cnt_d[s] = '0;
      end else if (grant_s && (arb_id_s == ID_W'(s))) begin
        ptr_d[s] = ptr_nxt_s;
        cnt_d[s] = cnt_nxt_s;
      end else begin
        ptr_d[s] = ptr_q[s];
        cnt_d[s] = cnt_q[s];
      end
    end
  end

  // Next round-robin pointer and write port. Address, data and id hold when nothing is granted.
  always_comb begin
    rr_d      = rr_q;
    wr_en_d   = grant_s;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_id_d   = wr_id_q;
    if (grant_s) begin
      rr_d      = (arb_id_s == ID_W'(NUM_STOCKS - 1)) ? {ID_W{1'b0}} : (arb_id_s + ID_W'(1));
      wr_addr_d = sel_base_s + ADDR_W'(sel_ptr_s);
      wr_data_d = sel_data_s;
      wr_id_d   = arb_id_s;
    end else begin
      rr_d      = rr_q;
    end
  end

  // Stall FSM. A new event can replace an accepted one in the same cycle.
  always_comb begin
    state_d   = state_q;
    win_id_d  = win_id_q;
    win_old_d = win_old_q;
    case (state_q)
      ST_ACCEPT: begin
        if (win_event_s) state_d = ST_WAIT_ACK;
        else             state_d = ST_ACCEPT;
      end
      ST_WAIT_ACK: begin
        if (win_event_s)      state_d = ST_WAIT_ACK;
        else if (i_win_ready) state_d = ST_ACCEPT;
        else                  state_d = ST_WAIT_ACK;
      end
      default: state_d = ST_ACCEPT;
    endcase
    // With a full window the next write slot is also the oldest sample.
    if (win_event_s) begin
      win_id_d  = arb_id_s;
      win_old_d = sel_base_s + ADDR_W'(ptr_nxt_s);
    end else begin
      win_id_d  = win_id_q;
    end
  end

  // Per-stock pointer and count registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int s = 0; s < NUM_STOCKS; s++) begin
        ptr_q[s] <= '0;
        cnt_q[s] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Scheduler state and output registers. Reset drops any pending write or event.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= ST_ACCEPT;
      rr_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_id_q   <= '0;
      win_id_q  <= '0;
      win_old_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_id_q   <= wr_id_d;
      win_id_q  <= win_id_d;
      win_old_q <= win_old_d;
    end
  end

  assign o_wr_en        = wr_en_q;
  assign o_wr_addr      = wr_addr_q;
  assign o_wr_data      = wr_data_q;
  assign o_wr_stock_id  = wr_id_q;
  assign o_win_valid    = (state_q == ST_WAIT_ACK);
  assign o_win_stock_id = win_id_q;
  assign o_win_oldest   = win_old_q;

endmodule

// File: tb/tb_volatility_wr_sched.sv
// -----------------------------------------------------------------------------
// tb_volatility_wr_sched
//   Self-checking bench for volatility_wr_sched at its default sizing.
//   A behavioural model predicts each grant and pushes the expected write to a
//   scoreboard queue. The write is popped and compared when the DUT strobes
//   o_wr_en. A constant vector table and hand-written sequences cover the
//   arbitration order, window wrap, stall, flush and reset corners.
// -----------------------------------------------------------------------------
module tb_volatility_wr_sched;

  localparam int NS = 4;
  localparam int BS = 20;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int AW = 7;

  logic             clk = 1'b0;
  logic             i_reset_n;
  logic [NS-1:0]    i_req_valid;
  logic [NS*DW-1:0] i_req_data;
  logic [NS-1:0]    o_req_ready;
  logic [NS-1:0]    i_flush;
  logic             o_wr_en;
  logic [AW-1:0]    o_wr_addr;
  logic [DW-1:0]    o_wr_data;
  logic [IW-1:0]    o_wr_stock_id;
  logic             o_win_valid;
  logic             i_win_ready;
  logic [IW-1:0]    o_win_stock_id;
  logic [AW-1:0]    o_win_oldest;

  always #5 clk = ~clk;

  volatility_wr_sched #(.NUM_STOCKS(NS), .BUFFER_SIZE(BS), .DATA_WIDTH(DW)) dut (
    .i_clk          (clk),
    .i_reset_n      (i_reset_n),
    .i_req_valid    (i_req_valid),
    .i_req_data     (i_req_data),
    .o_req_ready    (o_req_ready),
    .i_flush        (i_flush),
    .o_wr_en        (o_wr_en),
    .o_wr_addr      (o_wr_addr),
    .o_wr_data      (o_wr_data),
    .o_wr_stock_id  (o_wr_stock_id),
    .o_win_valid    (o_win_valid),
    .i_win_ready    (i_win_ready),
    .o_win_stock_id (o_win_stock_id),
    .o_win_oldest   (o_win_oldest)
  );

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
    int            id;
  } wr_exp_t;

  typedef struct {
    logic [3:0] v;
    logic [3:0] f;
    logic [3:0] exp_rdy;
    logic       exp_wen;
    int         exp_addr;
  } vec_t;

  int        n_tests = 0;
  int        n_fail  = 0;
  wr_exp_t   sb_q[$];
  int        ptr_m[NS];
  int        cnt_m[NS];
  int        rr_m;
  bit        winv_m;
  int        win_id_m, win_old_m, last_addr_m;
  int        seq = 0;
  logic [3:0] last_ready;
  vec_t      tbl[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      ptr_m[s] = 0;
      cnt_m[s] = 0;
    end
    rr_m        = 0;
    winv_m      = 1'b0;
    win_id_m    = 0;
    win_old_m   = 0;
    last_addr_m = 0;
    sb_q.delete();
  endtask

  // One clock cycle. Inputs are driven just after the falling edge, and outputs are checked at the next falling edge.
  task automatic cycle(input logic [3:0] v, input logic [3:0] f, input logic wr);
    logic [3:0] cand;
    logic [3:0] exp_rdy;
    int         g;
    bit         stall;
    wr_exp_t    e;
    i_req_valid = v;
    i_flush     = f;
    i_win_ready = wr;
    for (int s = 0; s < NS; s++) i_req_data[s*DW +: DW] = (32'(s) << 28) | 32'(seq);
    seq++;
    #1;
    stall = winv_m && !wr;
    cand  = v & ~f;
    g     = -1;
    if (!stall) begin
      for (int k = 0; k < NS; k++) begin
        int idx;
        idx = (rr_m + k) % NS;
        if (g < 0 && cand[idx]) g = idx;
      end
    end
    exp_rdy    = (g >= 0) ? 4'(1 << g) : 4'b0000;
    last_ready = o_req_ready;
    check("req_ready", o_req_ready, exp_rdy);
    if (winv_m && wr) winv_m = 1'b0;
    if (g >= 0) begin
      e.addr = g * BS + ptr_m[g];
      e.data = i_req_data[g*DW +: DW];
      e.id   = g;
      sb_q.push_back(e);
      ptr_m[g] = (ptr_m[g] + 1) % BS;
      if (cnt_m[g] < BS) cnt_m[g]++;
      rr_m = (g + 1) % NS;
      if (cnt_m[g] == BS) begin
        winv_m    = 1'b1;
        win_id_m  = g;
        win_old_m = g * BS + ptr_m[g];
      end
      last_addr_m = e.addr;
    end
    for (int s = 0; s < NS; s++) begin
      if (f[s]) begin
        ptr_m[s] = 0;
        cnt_m[s] = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("wr_en", o_wr_en, (g >= 0));
    if (o_wr_en) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 1'b1, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", o_wr_addr, e.addr);
        check("wr_data", o_wr_data, e.data);
        check("wr_stock_id", o_wr_stock_id, e.id);
      end
    end else begin
      check("wr_addr_hold", o_wr_addr, last_addr_m);
    end
    check("win_valid", o_win_valid, winv_m);
    if (winv_m) begin
      check("win_stock_id", o_win_stock_id, win_id_m);
      check("win_oldest", o_win_oldest, win_old_m);
    end
  endtask

  // Hold reset across one rising edge while v is presented, then check that every output is cleared.
  task automatic do_reset(input logic [3:0] v);
    i_reset_n   = 1'b0;
    i_req_valid = v;
    i_flush     = 4'b0000;
    i_win_ready = 1'b1;
    #1;
    check("rst_no_ready", o_req_ready, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    check("rst_outputs",
          {o_wr_en, o_wr_addr, o_wr_data, o_wr_stock_id, o_win_valid, o_win_stock_id, o_win_oldest},
          64'd0);
    model_reset();
    i_reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved_old;
    // Expected values below are derived by hand from a freshly reset DUT.
    tbl[0]  = '{4'hF, 4'h0, 4'b0001, 1'b1, 0};
    tbl[1]  = '{4'hF, 4'h0, 4'b0010, 1'b1, 20};
    tbl[2]  = '{4'hF, 4'h0, 4'b0100, 1'b1, 40};
    tbl[3]  = '{4'hF, 4'h0, 4'b1000, 1'b1, 60};
    tbl[4]  = '{4'hF, 4'h0, 4'b0001, 1'b1, 1};
    tbl[5]  = '{4'hF, 4'h0, 4'b0010, 1'b1, 21};
    tbl[6]  = '{4'hF, 4'h0, 4'b0100, 1'b1, 41};
    tbl[7]  = '{4'hF, 4'h0, 4'b1000, 1'b1, 61};
    tbl[8]  = '{4'hF, 4'h0, 4'b0001, 1'b1, 2};
    tbl[9]  = '{4'b0101, 4'h0, 4'b0100, 1'b1, 42};
    tbl[10] = '{4'b0101, 4'h0, 4'b0001, 1'b1, 3};
    tbl[11] = '{4'b0000, 4'h0, 4'b0000, 1'b0, 3};
    tbl[12] = '{4'b1000, 4'b1000, 4'b0000, 1'b0, 3};
    tbl[13] = '{4'b1001, 4'b0001, 4'b1000, 1'b1, 60};

    i_reset_n   = 1'b0;
    i_req_valid = '0;
    i_req_data  = '0;
    i_flush     = '0;
    i_win_ready = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset(4'h0);

    // Stock 1 alone fills its window. The event appears only on the 20th write.
    for (int i = 0; i < BS; i++) begin
      cycle(4'b0010, 4'b0000, 1'b1);
      check("s1_addr", o_wr_addr, 20 + i);
      check("s1_event", o_win_valid, (i == BS - 1));
    end
    check("s1_oldest", o_win_oldest, 20);
    // The 21st sample wraps to the start of the partition.
    cycle(4'b0010, 4'b0000, 1'b1);
    check("s1_wrap_addr", o_wr_addr, 20);
    check("s1_wrap_event", o_win_valid, 1'b1);
    check("s1_wrap_oldest", o_win_oldest, 21);

    // Vector table: round-robin order, sparse requests, idle cycles, flush priority.
    do_reset(4'h0);
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].v, tbl[i].f, 1'b1);
      check("tbl_ready", last_ready, tbl[i].exp_rdy);
      check("tbl_wen", o_wr_en, tbl[i].exp_wen);
      check("tbl_addr", o_wr_addr, tbl[i].exp_addr);
    end

    // Fill stock 2, then hold off the calculator for 5 cycles.
    while (cnt_m[2] < BS - 1) cycle(4'b0100, 4'b0000, 1'b1);
    cycle(4'b0100, 4'b0000, 1'b0);
    check("stall_event", o_win_valid, 1'b1);
    check("stall_event_id", o_win_stock_id, 2);
    saved_old = int'(o_win_oldest);
    for (int i = 0; i < 5; i++) begin
      cycle(4'hF, 4'b0000, 1'b0);
      check("stall_ready", last_ready, 4'b0000);
      check("stall_wen", o_wr_en, 1'b0);
      check("stall_oldest", o_win_oldest, saved_old);
    end
    cycle(4'hF, 4'b0000, 1'b1);
    check("resume_grant", (last_ready != 4'b0000), 1'b1);

    // A flush takes priority over a same-cycle request. Stock 0 restarts at address 0.
    cycle(4'b0001, 4'b0001, 1'b1);
    check("flush_no_grant", last_ready[0], 1'b0);
    for (int i = 0; i < BS; i++) begin
      cycle(4'b0001, 4'b0000, 1'b1);
      if (i == 0) check("flush_first_addr", o_wr_addr, 0);
      check("flush_event", o_win_valid, (i == BS - 1));
    end
    check("flush_oldest", o_win_oldest, 0);

    // Reset in the middle of traffic.
    cycle(4'hF, 4'b0000, 1'b1);
    cycle(4'hF, 4'b0000, 1'b1);
    do_reset(4'hF);
    cycle(4'b1000, 4'b0000, 1'b1);
    check("post_rst_addr", o_wr_addr, 60);

    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
